// File: rtl/data_memory_lsu_if.sv
// -----------------------------------------------------------------------------
// data_memory_lsu_if
// Request/response bundle between the MEM pipeline stage and data_memory_lsu.
//   req_valid    request present (master -> slave)
//   req_ready    slave can accept a request this cycle
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata    store data, right-justified
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    load result (0 for stores and errors)
//   rsp_err      access error, qualified by rsp_valid
//   busy         request in flight
// -----------------------------------------------------------------------------
interface data_memory_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/data_memory_lsu.sv
// -----------------------------------------------------------------------------
// data_memory_lsu
// Load/store unit in front of the data RAM. Serves one access at a time:
// byte-lane stores, sized sign/zero-extended loads, alignment/range checking
// and a configurable access latency (ACCESS_LAT cycles from accept to response).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any access in flight
//   bus    data_memory_lsu_if.slave (valid/ready request, valid-only response)
// -----------------------------------------------------------------------------
module data_memory_lsu #(
   parameter int MEM_BYTES  = 131072,
   parameter int ACCESS_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   data_memory_lsu_if.slave bus
);
   localparam int         ADDR_BITS = $clog2(MEM_BYTES);
   localparam int         WORDS     = MEM_BYTES / 4;
   // Last WAIT count before moving to RESP (unused when ACCESS_LAT == 1).
   localparam logic [3:0] WAIT_LAST = 4'(ACCESS_LAT - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Byte lanes touched by a store of the given size at the given offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << ofs;
         2'b01:   m = ofs[1] ? 4'b1100 : 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate right-justified store data onto every lane so the mask picks it.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      case (size)
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   // Pick the addressed byte/half out of a word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] ofs, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {ofs, 3'b000};
      case (size)
         2'b00:   r = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   r = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
         2'b10:   r = word;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Illegal size, misalignment, or an address beyond the decoded range.
   function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
      logic e;
      case (size)
         2'b00:   e = 1'b0;
         2'b01:   e = addr[0];
         2'b10:   e = (addr[1:0] != 2'b00);
         default: e = 1'b1;
      endcase
      return e | ((addr >> ADDR_BITS) != 32'd0);
   endfunction

   state_t                 state_r, state_next_s;
   logic [3:0]             cnt_r, cnt_next_s;
   logic                   ready_r, busy_r;
   logic                   rsp_valid_r, rsp_err_r;
   logic [31:0]            rsp_rdata_r;

   logic                   we_r, uns_r, err_r;
   logic [ADDR_BITS-1:0]   addr_r;
   logic [1:0]             size_r;
   logic [31:0]            wdata_r;

   logic                   accept_s, commit_s, req_err_s;
   logic                   cur_we_s, cur_uns_s, cur_err_s;
   logic [ADDR_BITS-1:0]   cur_addr_s;
   logic [1:0]             cur_size_s;
   logic [31:0]            cur_wdata_s;
   logic [ADDR_BITS-3:0]   cur_idx_s;
   logic [3:0]             be_s;
   logic [31:0]            wlanes_s, rd_word_s, load_s;
   logic                   wr_en_s;

   logic [31:0]            mem_r [WORDS];

   assign accept_s  = bus.req_valid && ready_r;
   assign req_err_s = access_err(bus.req_addr, bus.req_size);

   // Access fields: live inputs in IDLE (needed when ACCESS_LAT == 1), captured copy otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         cur_we_s    = bus.req_we;
         cur_addr_s  = bus.req_addr[ADDR_BITS-1:0];
         cur_size_s  = bus.req_size;
         cur_uns_s   = bus.req_unsigned;
         cur_wdata_s = bus.req_wdata;
         cur_err_s   = req_err_s;
      end else begin
         cur_we_s    = we_r;
         cur_addr_s  = addr_r;
         cur_size_s  = size_r;
         cur_uns_s   = uns_r;
         cur_wdata_s = wdata_r;
         cur_err_s   = err_r;
      end
   end

   assign cur_idx_s = cur_addr_s[ADDR_BITS-1:2];
   assign be_s      = lane_mask(cur_size_s, cur_addr_s[1:0]);
   assign wlanes_s  = store_lanes(cur_size_s, cur_wdata_s);
   assign rd_word_s = mem_r[cur_idx_s];
   assign wr_en_s   = commit_s && cur_we_s && !cur_err_s;
   assign load_s    = (cur_we_s || cur_err_s) ? 32'h0000_0000
                    : load_extend(rd_word_s, cur_size_s, cur_addr_s[1:0], cur_uns_s);

   // Next-state logic; commit_s marks the edge that enters RESP.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      commit_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (ACCESS_LAT == 1) begin
                  state_next_s = ST_RESP;
                  commit_s     = 1'b1;
               end else begin
                  state_next_s = ST_WAIT;
                  cnt_next_s   = 4'd0;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == WAIT_LAST) begin
               state_next_s = ST_RESP;
               commit_s     = 1'b1;
            end else begin
               cnt_next_s   = cnt_r + 4'd1;
            end
         end
         ST_RESP: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, handshake outputs and the registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         ready_r     <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         ready_r     <= (state_next_s == ST_IDLE);
         busy_r      <= (state_next_s != ST_IDLE);
         rsp_valid_r <= commit_s;
         if (commit_s) begin
            rsp_rdata_r <= load_s;
            rsp_err_r   <= cur_err_s;
         end
      end
   end

   // Capture the request at accept so later input changes have no effect.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         size_r  <= 2'b00;
         uns_r   <= 1'b0;
         wdata_r <= 32'h0000_0000;
         err_r   <= 1'b0;
      end else if (accept_s) begin
         we_r    <= bus.req_we;
         addr_r  <= bus.req_addr[ADDR_BITS-1:0];
         size_r  <= bus.req_size;
         uns_r   <= bus.req_unsigned;
         wdata_r <= bus.req_wdata;
         err_r   <= req_err_s;
      end
   end

   // Data RAM: byte-lane write at commit; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_en_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[cur_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.busy      = busy_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;
endmodule
